// File: rtl/ycbcr422_packer.sv
// ycbcr422_packer: 4:4:4 YCbCr pixels to a 4:2:2 YUYV word stream with sof/eol tags and an output FIFO
module ycbcr422_packer #(
   parameter int IMG_W = 640,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sof,
   input  logic [7:0]  Y,
   input  logic [7:0]  Cb,
   input  logic [7:0]  Cr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_sof,
   output logic        out_eol,
   output logic        sync_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [11:0] LAST = 12'(IMG_W - 1);
   localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);

   logic [11:0]   x_q, x_d, px;
   logic [7:0]    y0_q, y0_d, cb0_q, cb0_d, cr0_q, cr0_d;
   logic          sof0_q, sof0_d, sync_err_q, sync_err_d;
   logic          accept, odd, last, push, pop;
   logic [7:0]    cb_avg, cr_avg;
   logic [17:0]   w0, w1;
   logic [17:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign in_ready  = cnt_q <= RDY_MAX;
   assign out_valid = cnt_q != '0;
   assign {out_sof, out_eol, out_data} = out_valid ? mem_q[rd_q] : '0;
   assign sync_err  = sync_err_q;

   // Column tracking, even-pixel hold, chroma averaging and FIFO bookkeeping
   always_comb begin
      accept     = in_valid & in_ready;
      px         = in_sof ? '0 : x_q;
      odd        = px[0];
      last       = px == LAST;
      push       = accept & (odd | last);
      pop        = out_valid & out_ready;
      cb_avg     = 8'(({1'b0, cb0_q} + {1'b0, Cb} + 9'd1) >> 1);
      cr_avg     = 8'(({1'b0, cr0_q} + {1'b0, Cr} + 9'd1) >> 1);
      w0         = odd ? {sof0_q, 1'b0, cb_avg, y0_q} : {2'b00, Cb, Y};
      w1         = {1'b0, last, odd ? cr_avg : Cr, Y};
      x_d        = accept ? (last ? '0 : px + 12'd1) : x_q;
      y0_d       = accept & !odd ? Y : y0_q;
      cb0_d      = accept & !odd ? Cb : cb0_q;
      cr0_d      = accept & !odd ? Cr : cr0_q;
      sof0_d     = accept & !odd ? in_sof : sof0_q;
      sync_err_d = accept & in_sof & (x_q != '0);
      wr_d       = push ? wr_q + AW'(2) : wr_q;
      rd_d       = pop ? rd_q + AW'(1) : rd_q;
      cnt_d      = cnt_q + (push ? CW'(2) : '0) - CW'(pop);
   end

   // State registers; reset drops the held pixel and empties the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= '0;
         y0_q       <= '0;
         cb0_q      <= '0;
         cr0_q      <= '0;
         sof0_q     <= 1'b0;
         sync_err_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         x_q        <= x_d;
         y0_q       <= y0_d;
         cb0_q      <= cb0_d;
         cr0_q      <= cr0_d;
         sof0_q     <= sof0_d;
         sync_err_q <= sync_err_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   // FIFO storage takes both words of a pair in one cycle
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q]          <= w0;
         mem_q[wr_q + AW'(1)] <= w1;
      end
   end
endmodule

// File: tb/tb_ycbcr422_packer.sv
// tb_ycbcr422_packer: directed checks of the 4:2:2 packer at IMG_W=4 and IMG_W=3
module tb_ycbcr422_packer;
   logic        clk = 0, rst_n = 1, in_valid = 0, in_sof = 0, out_ready = 0;
   logic [7:0]  y = 0, cb = 0, cr = 0;
   logic        rdy4, ov4, sof4, eol4, se4, rdy3, ov3, sof3, eol3, se3;
   logic [15:0] d4, d3;
   int          checks = 0, failures = 0;
   logic [17:0] q4[$], q3[$];

   always #5 clk = ~clk;

   ycbcr422_packer #(.IMG_W(4), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_sof(in_sof),
      .Y(y), .Cb(cb), .Cr(cr), .out_valid(ov4), .out_ready(out_ready), .out_data(d4),
      .out_sof(sof4), .out_eol(eol4), .sync_err(se4));

   ycbcr422_packer #(.IMG_W(3), .DEPTH(4)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .in_sof(in_sof),
      .Y(y), .Cb(cb), .Cr(cr), .out_valid(ov3), .out_ready(out_ready), .out_data(d3),
      .out_sof(sof3), .out_eol(eol3), .sync_err(se3));

   always @(negedge clk) begin
      if (rst_n && out_ready) begin
         if (ov4) q4.push_back({sof4, eol4, d4});
         if (ov3) q3.push_back({sof3, eol3, d3});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int sel, input logic [7:0] yy, input logic [7:0] cc, input logic [7:0] rr, input logic s);
      int t = 0;
      y = yy; cb = cc; cr = rr; in_sof = s; in_valid = 1;
      while (!((sel == 3) ? rdy3 : rdy4) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("send_ready", t < 100, 1);
      @(posedge clk);
      #1;
      in_valid = 0;
      in_sof = 0;
   endtask

   task automatic chk_stream(input string tag, input int sel, input int n, input logic [17:0] e [8]);
      int sz = (sel == 3) ? q3.size() : q4.size();
      chk($sformatf("%s_len", tag), sz, n);
      for (int i = 0; i < n; i++) begin
         logic [17:0] g;
         g = (i >= sz) ? '1 : ((sel == 3) ? q3[i] : q4[i]);
         chk($sformatf("%s_w%0d", tag, i), g, e[i]);
      end
      q3.delete();
      q4.delete();
   endtask

   initial begin
      logic [17:0] ex[8];
      logic [17:0] ex_flow[8];
      logic [7:0]  py[8], pb[8], pr[8];
      py = '{100, 101, 102, 103, 104, 105, 106, 107};
      pb = '{10, 20, 30, 41, 50, 60, 255, 254};
      pr = '{10, 21, 30, 40, 51, 60, 254, 255};
      ex_flow = '{18'h20F64, 18'h01065, 18'h02466, 18'h12367, 18'h03768, 18'h03869, 18'h0FF6A, 18'h1FF6B};
      #1 rst_n = 0;
      #12;
      chk("rst_valid", ov4, 0);
      chk("rst_data", d4, 0);
      chk("rst_sof", sof4, 0);
      chk("rst_eol", eol4, 0);
      chk("rst_sync", se4, 0);
      chk("rst_ready", rdy4, 1);
      @(posedge clk);
      #1 rst_n = 1;
      out_ready = 1;
      send(4, 10, 100, 200, 1);
      send(4, 20, 101, 203, 0);
      chk("lat_valid", ov4, 1);
      chk("lat_data", d4, 16'h650A);
      chk("lat_sof", sof4, 1);
      send(4, 30, 0, 255, 0);
      send(4, 40, 1, 255, 0);
      idle(5);
      ex = '{18'h2650A, 18'h0CA14, 18'h0011E, 18'h1FF28, 0, 0, 0, 0};
      chk_stream("basic", 4, 4, ex);
      send(4, 1, 254, 3, 0);
      send(4, 2, 255, 4, 0);
      send(4, 3, 0, 0, 0);
      send(4, 4, 1, 1, 0);
      idle(5);
      ex = '{18'h0FF01, 18'h00402, 18'h00103, 18'h10104, 0, 0, 0, 0};
      chk_stream("round", 4, 4, ex);
      send(4, 11, 10, 20, 1);
      chk("sync_quiet", se4, 0);
      send(4, 12, 30, 40, 0);
      send(4, 13, 50, 60, 1);
      chk("sync_pulse", se4, 1);
      send(4, 14, 70, 80, 0);
      chk("sync_once", se4, 0);
      send(4, 15, 0, 0, 0);
      send(4, 16, 2, 2, 0);
      idle(5);
      ex = '{18'h2140B, 18'h01E0C, 18'h23C0D, 18'h0460E, 18'h0010F, 18'h10110, 0, 0};
      chk_stream("sync", 4, 6, ex);
      for (int i = 0; i < 8; i++) send(4, py[i], pb[i], pr[i], i == 0);
      idle(5);
      chk_stream("flow", 4, 8, ex_flow);
      out_ready = 0;
      for (int i = 0; i < 3; i++) send(4, py[i], pb[i], pr[i], i == 0);
      chk("stall_rdy_two", rdy4, 1);
      send(4, py[3], pb[3], pr[3], 0);
      chk("stall_rdy_full", rdy4, 0);
      chk("stall_valid", ov4, 1);
      y = py[4]; cb = pb[4]; cr = pr[4]; in_valid = 1;
      idle(16);
      chk("stall_hold_rdy", rdy4, 0);
      chk("stall_head", d4, 16'h0F64);
      chk("stall_head_sof", sof4, 1);
      out_ready = 1;
      for (int i = 4; i < 8; i++) send(4, py[i], pb[i], pr[i], 0);
      idle(8);
      chk_stream("stall", 4, 8, ex_flow);
      rst_n = 0;
      idle(1);
      rst_n = 1;
      send(3, 5, 50, 60, 1);
      send(3, 6, 52, 62, 0);
      send(3, 7, 70, 80, 0);
      idle(5);
      ex = '{18'h23305, 18'h03D06, 18'h04607, 18'h15007, 0, 0, 0, 0};
      chk_stream("odd", 3, 4, ex);
      out_ready = 0;
      send(4, 100, 10, 10, 1);
      send(4, 101, 20, 21, 0);
      send(4, 102, 30, 30, 0);
      chk("pre_rst_valid", ov4, 1);
      chk("pre_rst_data", d4, 16'h0F64);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_valid", ov4, 0);
      chk("mid_rst_data", d4, 0);
      chk("mid_rst_sof", sof4, 0);
      chk("mid_rst_eol", eol4, 0);
      chk("mid_rst_ready", rdy4, 1);
      @(posedge clk);
      #1 rst_n = 1;
      out_ready = 1;
      send(4, 20, 100, 100, 0);
      send(4, 21, 102, 104, 0);
      idle(5);
      ex = '{18'h06514, 18'h06615, 0, 0, 0, 0, 0, 0};
      chk_stream("fresh", 4, 2, ex);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
